// File: rtl/keystream_gen_if.sv
// keystream_gen_if: signal bundle between keystream_gen, the host config path,
// data_flow_control and the AES round core.
//
// Handshake semantics: every request/acknowledge line here is a single-cycle
// pulse, not a level. key_sync_load, key_and_sync_req and new_sync_req are
// sampled on the rising clock edge on which they are high. key_and_sync_vld,
// cipher_block_vld and aes_start are registered and high for exactly one
// cycle. aes_done is a one-cycle pulse from the core; aes_result is only
// meaningful while aes_done is high. cipher_block, aes_key and aes_block are
// held steady between their qualifying pulses.
interface keystream_gen_if;
  logic [127:0] key_in;
  logic [127:0] sync_in;
  logic         key_sync_load;
  logic         key_and_sync_req;
  logic         new_sync_req;
  logic         key_and_sync_vld;
  logic [127:0] cipher_block;
  logic         cipher_block_vld;
  logic [127:0] aes_key;
  logic [127:0] aes_block;
  logic         aes_start;
  logic         aes_done;
  logic [127:0] aes_result;
  logic         ctr_overflow;

  // Keystream generator side.
  modport slave (
    input  key_in, sync_in, key_sync_load, key_and_sync_req, new_sync_req,
    input  aes_done, aes_result,
    output key_and_sync_vld, cipher_block, cipher_block_vld,
    output aes_key, aes_block, aes_start, ctr_overflow
  );

  // Host / flow control / AES core side.
  modport master (
    output key_in, sync_in, key_sync_load, key_and_sync_req, new_sync_req,
    output aes_done, aes_result,
    input  key_and_sync_vld, cipher_block, cipher_block_vld,
    input  aes_key, aes_block, aes_start, ctr_overflow
  );
endinterface

// File: rtl/keystream_gen.sv
// keystream_gen: counter-mode keystream generator for the AES-128 datapath.
// Encrypts {active_sync[127:CTR_W], ctr} through an external AES core using an
// aes_start / aes_done handshake and returns the result as cipher_block.
// Key and sync are staged by key_sync_load and become active only when a
// key_and_sync_req is accepted (message start).
//
// Optional feature: define KEYSTREAM_PREFETCH_EN to keep a one-entry prefetch
// buffer holding the next keystream block, computed ahead of the request.
// Without it, blocks are generated on demand only.
module keystream_gen #(
  parameter int CTR_W = 32
) (
  input  logic           clk,
  input  logic           rst,        // asynchronous, active low
  keystream_gen_if.slave ks,
  output logic [1:0]     dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_KEY = 2'd1,
    S_READY    = 2'd2,
    S_BUSY     = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [127:0]         stg_key_q, stg_key_d;
  logic [127-CTR_W:0]   stg_sync_q, stg_sync_d;
  logic                 stg_vld_q, stg_vld_d;
  logic [127:0]         act_key_q, act_key_d;
  logic [127-CTR_W:0]   act_sync_q, act_sync_d;
  logic [CTR_W-1:0]     ctr_q, ctr_d;
  logic                 pend_q, pend_d;
  logic                 ovf_q, ovf_d;
  logic                 drop_q, drop_d;      // swallow the next aes_done (aborted op)
  logic                 ksv_q, ksv_d;
  logic [127:0]         cb_q, cb_d;
  logic                 cbv_q, cbv_d;
  logic                 start_q, start_d;
  logic [127:0]         blk_q, blk_d;
`ifdef KEYSTREAM_PREFETCH_EN
  logic                 pf_vld_q, pf_vld_d;  // prefetch buffer holds a block
  logic [127:0]         pf_data_q, pf_data_d;
  logic                 pf_op_q, pf_op_d;    // in-flight op is a prefetch
`endif

  logic accept;   // copy staging to active this cycle
  logic to_wait;  // key request without staged key
  logic issue;    // launch an AES operation this cycle
  logic want;     // a block request is outstanding

  // Low sync bits are replaced by the counter and never used.
  logic [CTR_W-1:0] sync_lo_unused;
  assign sync_lo_unused = ks.sync_in[CTR_W-1:0];

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    stg_key_d  = stg_key_q;
    stg_sync_d = stg_sync_q;
    stg_vld_d  = stg_vld_q;
    act_key_d  = act_key_q;
    act_sync_d = act_sync_q;
    ctr_d      = ctr_q;
    pend_d     = pend_q;
    ovf_d      = ovf_q;
    drop_d     = drop_q;
    cb_d       = cb_q;
    blk_d      = blk_q;
    ksv_d      = 1'b0;
    cbv_d      = 1'b0;
    start_d    = 1'b0;
`ifdef KEYSTREAM_PREFETCH_EN
    pf_vld_d   = pf_vld_q;
    pf_data_d  = pf_data_q;
    pf_op_d    = pf_op_q;
`endif
    accept     = 1'b0;
    to_wait    = 1'b0;
    issue      = 1'b0;
    want       = ks.new_sync_req || pend_q;

    // Staging is written any time; it only matters at the next accept.
    if (ks.key_sync_load) begin
      stg_key_d  = ks.key_in;
      stg_sync_d = ks.sync_in[127:CTR_W];
      stg_vld_d  = 1'b1;
    end

    if (ks.aes_done && drop_q) drop_d = 1'b0;

    if (state_q == S_WAIT_KEY) begin
      accept = stg_vld_q;
    end else if (ks.key_and_sync_req) begin
      accept  = stg_vld_q;
      to_wait = !stg_vld_q;
    end

    if (accept || to_wait) begin
      pend_d = 1'b0;
      // Leaving BUSY early: the core's pending completion must not be used.
      if (state_q == S_BUSY && !ks.aes_done) drop_d = 1'b1;
`ifdef KEYSTREAM_PREFETCH_EN
      pf_vld_d = 1'b0;
      pf_op_d  = 1'b0;
`endif
    end

    if (accept) begin
      act_key_d  = stg_key_q;
      act_sync_d = stg_sync_q;
      ctr_d      = '0;
      ovf_d      = 1'b0;
      ksv_d      = 1'b1;
      blk_d      = {stg_sync_q, {CTR_W{1'b0}}};
      state_d    = S_READY;
    end else if (to_wait) begin
      state_d = S_WAIT_KEY;
    end else begin
      case (state_q)
        S_READY: begin
`ifdef KEYSTREAM_PREFETCH_EN
          if (pf_vld_q && want) begin
            cb_d     = pf_data_q;
            cbv_d    = 1'b1;
            pf_vld_d = 1'b0;
            pf_op_d  = 1'b1;
            issue    = 1'b1;
          end else if (!pf_vld_q && !drop_q) begin
            pf_op_d = !want;
            issue   = 1'b1;
          end else if (ks.new_sync_req) begin
            pend_d = 1'b1;
          end
`else
          if (want && !drop_q) issue = 1'b1;
          else if (ks.new_sync_req) pend_d = 1'b1;
`endif
        end
        S_BUSY: begin
          if (ks.aes_done && !drop_q) begin
            state_d = S_READY;
`ifdef KEYSTREAM_PREFETCH_EN
            if (pf_op_q && !want) begin
              pf_data_d = ks.aes_result;
              pf_vld_d  = 1'b1;
            end else begin
              cb_d  = ks.aes_result;
              cbv_d = 1'b1;
              if (pf_op_q) pend_d = 1'b0;
              else if (ks.new_sync_req) pend_d = 1'b1;
            end
`else
            cb_d  = ks.aes_result;
            cbv_d = 1'b1;
            if (ks.new_sync_req) pend_d = 1'b1;
`endif
          end else if (ks.new_sync_req) begin
            pend_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (issue) begin
      start_d = 1'b1;
      blk_d   = {act_sync_q, ctr_q};
      ctr_d   = ctr_q + CTR_W'(1);
      if (&ctr_q) ovf_d = 1'b1;
      pend_d  = 1'b0;
      state_d = S_BUSY;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      stg_key_q  <= '0;
      stg_sync_q <= '0;
      stg_vld_q  <= 1'b0;
      act_key_q  <= '0;
      act_sync_q <= '0;
      ctr_q      <= '0;
      pend_q     <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
      ksv_q      <= 1'b0;
      cb_q       <= '0;
      cbv_q      <= 1'b0;
      start_q    <= 1'b0;
      blk_q      <= '0;
`ifdef KEYSTREAM_PREFETCH_EN
      pf_vld_q   <= 1'b0;
      pf_data_q  <= '0;
      pf_op_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      stg_key_q  <= stg_key_d;
      stg_sync_q <= stg_sync_d;
      stg_vld_q  <= stg_vld_d;
      act_key_q  <= act_key_d;
      act_sync_q <= act_sync_d;
      ctr_q      <= ctr_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
      ksv_q      <= ksv_d;
      cb_q       <= cb_d;
      cbv_q      <= cbv_d;
      start_q    <= start_d;
      blk_q      <= blk_d;
`ifdef KEYSTREAM_PREFETCH_EN
      pf_vld_q   <= pf_vld_d;
      pf_data_q  <= pf_data_d;
      pf_op_q    <= pf_op_d;
`endif
    end
  end

  assign ks.key_and_sync_vld = ksv_q;
  assign ks.cipher_block     = cb_q;
  assign ks.cipher_block_vld = cbv_q;
  assign ks.aes_key          = act_key_q;
  assign ks.aes_block        = blk_q;
  assign ks.aes_start        = start_q;
  assign ks.ctr_overflow     = ovf_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_keystream_gen.sv
// tb_keystream_gen: directed bench for keystream_gen with a stub AES core
// (done 10 cycles after start, result = block ^ 1). CTR_W is 4 so counter
// wrap is reachable quickly.
`timescale 1ns/1ps
module tb_keystream_gen;
  localparam int CTR_W = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  keystream_gen_if bus();

  keystream_gen #(.CTR_W(CTR_W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .ks        (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stub core + output logging ----------------
  int           core_cnt = 0;
  logic [127:0] core_blk = '0;
  int           ksv_cyc_q[$];
  int           start_cyc_q[$];
  int           cbv_cyc_q[$];
  logic [127:0] start_blk_q[$];
  logic [127:0] got_q[$];
  logic [127:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.key_and_sync_vld) ksv_cyc_q.push_back(cyc);
    if (bus.cipher_block_vld) begin
      got_q.push_back(bus.cipher_block);
      cbv_cyc_q.push_back(cyc);
    end
    bus.aes_done = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        bus.aes_done   = 1'b1;
        bus.aes_result = core_blk ^ 128'h1;
      end
    end
    if (bus.aes_start) begin
      start_blk_q.push_back(bus.aes_block);
      start_cyc_q.push_back(cyc);
      core_blk = bus.aes_block;
      core_cnt = 10;
    end
  end

  // ---------------- constants ----------------
  logic [127:0] key_a;
  logic [127:0] sync_a;
  logic [127:0] key_v;
  logic [127:0] sync_v;

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    ksv_cyc_q.delete();
    start_cyc_q.delete();
    cbv_cyc_q.delete();
    start_blk_q.delete();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_new(output int c);
    @(negedge clk);
    bus.new_sync_req = 1'b1;
    c = cyc;
    @(negedge clk);
    bus.new_sync_req = 1'b0;
  endtask

  task automatic pulse_ks_req(output int c);
    @(negedge clk);
    bus.key_and_sync_req = 1'b1;
    c = cyc;
    @(negedge clk);
    bus.key_and_sync_req = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] k, input logic [127:0] s, output int c);
    @(negedge clk);
    bus.key_in        = k;
    bus.sync_in       = s;
    bus.key_sync_load = 1'b1;
    c = cyc;
    @(negedge clk);
    bus.key_sync_load = 1'b0;
  endtask

  task automatic wait_cbv(input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (got_q.size() >= n) break;
      @(negedge clk);
    end
  endtask

  function automatic logic [127:0] ctr_block(input logic [127:0] s, input int i);
    logic [CTR_W-1:0] c;
    c = CTR_W'(i);
    return {s[127:CTR_W], c};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    bus.key_in = '0;
    bus.sync_in = '0;
    bus.key_sync_load = 1'b0;
    bus.key_and_sync_req = 1'b0;
    bus.new_sync_req = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.key_and_sync_vld !== 1'b0) begin n_bad++; $display("FAIL reset_ksv: got %b want 0", bus.key_and_sync_vld); end
    n_cmp++; if (bus.cipher_block_vld !== 1'b0) begin n_bad++; $display("FAIL reset_cbv: got %b want 0", bus.cipher_block_vld); end
    n_cmp++; if (bus.aes_start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b want 0", bus.aes_start); end
    n_cmp++; if (bus.ctr_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", bus.ctr_overflow); end
    n_cmp++; if (bus.cipher_block !== 128'h0) begin n_bad++; $display("FAIL reset_cb: got %h want 0", bus.cipher_block); end
    n_cmp++; if (bus.aes_key !== 128'h0) begin n_bad++; $display("FAIL reset_key: got %h want 0", bus.aes_key); end
    n_cmp++; if (bus.aes_block !== 128'h0) begin n_bad++; $display("FAIL reset_block: got %h want 0", bus.aes_block); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_missing_key();
    int c;
    int k;
    int got_c;
    clear_logs();
    pulse_ks_req(c);
    repeat (4) @(negedge clk);
    n_cmp++; if (ksv_cyc_q.size() != 0) begin n_bad++; $display("FAIL nokey_ksv: got %0d pulses want 0", ksv_cyc_q.size()); end
    n_cmp++; if (dbg_state !== 2'd1) begin n_bad++; $display("FAIL nokey_state: got %0d want 1", dbg_state); end
    pulse_new(c);
    repeat (3) @(negedge clk);
    n_cmp++; if (start_cyc_q.size() != 0) begin n_bad++; $display("FAIL nokey_start: got %0d starts want 0", start_cyc_q.size()); end
    load_key(key_a, sync_a, k);
    repeat (4) @(negedge clk);
    got_c = (ksv_cyc_q.size() == 1) ? ksv_cyc_q[0] : -1;
    n_cmp++; if (got_c != k + 2) begin n_bad++; $display("FAIL nokey_ksv_lat: got cycle %0d want %0d", got_c, k + 2); end
    n_cmp++; if (bus.aes_key !== key_a) begin n_bad++; $display("FAIL nokey_key: got %h want %h", bus.aes_key, key_a); end
    n_cmp++; if (bus.aes_block !== ctr_block(sync_a, 0)) begin n_bad++; $display("FAIL nokey_block: got %h want %h", bus.aes_block, ctr_block(sync_a, 0)); end
    n_cmp++; if (dbg_state !== 2'd2) begin n_bad++; $display("FAIL nokey_ready: got %0d want 2", dbg_state); end
  endtask

  task automatic test_key_load();
    int c;
    int n;
    int got_c;
    clear_logs();
    load_key(key_v, sync_v, c);
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.aes_key !== key_a) begin n_bad++; $display("FAIL load_staging_only: got %h want %h", bus.aes_key, key_a); end
    pulse_ks_req(n);
    repeat (2) @(negedge clk);
    got_c = (ksv_cyc_q.size() == 1) ? ksv_cyc_q[0] : -1;
    n_cmp++; if (got_c != n + 1) begin n_bad++; $display("FAIL load_ksv_lat: got cycle %0d want %0d", got_c, n + 1); end
    n_cmp++; if (bus.aes_key !== key_v) begin n_bad++; $display("FAIL load_key: got %h want %h", bus.aes_key, key_v); end
  endtask

  task automatic test_counter_seq();
    int c;
    int c0;
    int got_c;
    logic [127:0] eb;
    logic [127:0] ex;
    logic [127:0] gb;
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      pulse_new(c);
      if (i == 0) c0 = c;
      exp_q.push_back(ctr_block(sync_v, i) ^ 128'h1);
      wait_cbv(i + 1, 30);
    end
    got_c = (start_cyc_q.size() > 0) ? start_cyc_q[0] : -1;
    n_cmp++; if (got_c != c0 + 1) begin n_bad++; $display("FAIL seq_start_lat: got cycle %0d want %0d", got_c, c0 + 1); end
    n_cmp++; if (got_q.size() != 3) begin n_bad++; $display("FAIL seq_cbv_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      eb = ctr_block(sync_v, i);
      gb = (i < start_blk_q.size()) ? start_blk_q[i] : '0;
      n_cmp++; if (gb !== eb) begin n_bad++; $display("FAIL seq_block%0d: got %h want %h", i, gb, eb); end
      ex = exp_q.pop_front();
      gb = (i < got_q.size()) ? got_q[i] : '0;
      n_cmp++; if (gb !== ex) begin n_bad++; $display("FAIL seq_data%0d: got %h want %h", i, gb, ex); end
    end
  endtask

  task automatic test_back_to_back();
    int c;
    int s1;
    int v0;
    logic [127:0] gb;
    logic [127:0] eb;
    clear_logs();
    pulse_new(c);
    repeat (2) @(negedge clk);
    pulse_new(c);
    pulse_new(c);
    wait_cbv(2, 60);
    repeat (15) @(negedge clk);
    n_cmp++; if (start_cyc_q.size() != 2) begin n_bad++; $display("FAIL b2b_starts: got %0d want 2", start_cyc_q.size()); end
    n_cmp++; if (got_q.size() != 2) begin n_bad++; $display("FAIL b2b_cbv_count: got %0d want 2", got_q.size()); end
    s1 = (start_cyc_q.size() > 1) ? start_cyc_q[1] : -1;
    v0 = (cbv_cyc_q.size() > 0) ? cbv_cyc_q[0] : -10;
    n_cmp++; if (s1 != v0 + 1) begin n_bad++; $display("FAIL b2b_pend_lat: got cycle %0d want %0d", s1, v0 + 1); end
    eb = ctr_block(sync_v, 4);
    gb = (start_blk_q.size() > 1) ? start_blk_q[1] : '0;
    n_cmp++; if (gb !== eb) begin n_bad++; $display("FAIL b2b_block: got %h want %h", gb, eb); end
    gb = (got_q.size() > 1) ? got_q[1] : '0;
    n_cmp++; if (gb !== (eb ^ 128'h1)) begin n_bad++; $display("FAIL b2b_data: got %h want %h", gb, eb ^ 128'h1); end
  endtask

  task automatic test_wrap();
    int c;
    int n;
    int got_c;
    logic ovf15;
    logic [127:0] gb;
    logic [127:0] eb;
    pulse_ks_req(c);
    repeat (2) @(negedge clk);
    clear_logs();
    ovf15 = 1'bx;
    for (int i = 0; i < 17; i++) begin
      pulse_new(c);
      wait_cbv(i + 1, 30);
      if (i == 14) ovf15 = bus.ctr_overflow;
    end
    n_cmp++; if (ovf15 !== 1'b0) begin n_bad++; $display("FAIL wrap_ovf_early: got %b want 0", ovf15); end
    n_cmp++; if (bus.ctr_overflow !== 1'b1) begin n_bad++; $display("FAIL wrap_ovf: got %b want 1", bus.ctr_overflow); end
    eb = ctr_block(sync_v, 0);
    gb = (start_blk_q.size() > 16) ? start_blk_q[16] : '0;
    n_cmp++; if (gb !== eb) begin n_bad++; $display("FAIL wrap_block17: got %h want %h", gb, eb); end
    gb = (got_q.size() > 16) ? got_q[16] : '0;
    n_cmp++; if (gb !== (eb ^ 128'h1)) begin n_bad++; $display("FAIL wrap_data17: got %h want %h", gb, eb ^ 128'h1); end
    // Key request and block request in the same cycle: key request wins.
    clear_logs();
    @(negedge clk);
    bus.key_and_sync_req = 1'b1;
    bus.new_sync_req     = 1'b1;
    n = cyc;
    @(negedge clk);
    bus.key_and_sync_req = 1'b0;
    bus.new_sync_req     = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.ctr_overflow !== 1'b0) begin n_bad++; $display("FAIL wrap_ovf_clear: got %b want 0", bus.ctr_overflow); end
    got_c = (ksv_cyc_q.size() == 1) ? ksv_cyc_q[0] : -1;
    n_cmp++; if (got_c != n + 1) begin n_bad++; $display("FAIL same_cycle_ksv: got cycle %0d want %0d", got_c, n + 1); end
    n_cmp++; if (start_cyc_q.size() != 0) begin n_bad++; $display("FAIL same_cycle_start: got %0d starts want 0", start_cyc_q.size()); end
  endtask

  task automatic test_abort_key();
    int c;
    int k;
    int got_c;
    logic [127:0] gb;
    pulse_new(c);
    wait_cbv(1, 30);
    clear_logs();
    pulse_new(c);
    repeat (3) @(negedge clk);
    pulse_ks_req(k);
    repeat (20) @(negedge clk);
    n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL abort_key_cbv: got %0d pulses want 0", got_q.size()); end
    got_c = (ksv_cyc_q.size() == 1) ? ksv_cyc_q[0] : -1;
    n_cmp++; if (got_c != k + 1) begin n_bad++; $display("FAIL abort_key_ksv: got cycle %0d want %0d", got_c, k + 1); end
    n_cmp++; if (bus.aes_block !== ctr_block(sync_v, 0)) begin n_bad++; $display("FAIL abort_key_block: got %h want %h", bus.aes_block, ctr_block(sync_v, 0)); end
    n_cmp++; if (dbg_state !== 2'd2) begin n_bad++; $display("FAIL abort_key_state: got %0d want 2", dbg_state); end
    pulse_new(c);
    wait_cbv(1, 30);
    gb = (got_q.size() > 0) ? got_q[0] : '0;
    n_cmp++; if (gb !== (ctr_block(sync_v, 0) ^ 128'h1)) begin n_bad++; $display("FAIL abort_key_restart: got %h want %h", gb, ctr_block(sync_v, 0) ^ 128'h1); end
  endtask

  task automatic test_abort_reset();
    int c;
    clear_logs();
    pulse_new(c);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.aes_key !== 128'h0) begin n_bad++; $display("FAIL rst_busy_key: got %h want 0", bus.aes_key); end
    n_cmp++; if (bus.aes_block !== 128'h0) begin n_bad++; $display("FAIL rst_busy_block: got %h want 0", bus.aes_block); end
    n_cmp++; if (bus.cipher_block !== 128'h0) begin n_bad++; $display("FAIL rst_busy_cb: got %h want 0", bus.cipher_block); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL rst_busy_state: got %0d want 0", dbg_state); end
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    pulse_new(c);
    repeat (4) @(negedge clk);
    n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL rst_busy_cbv: got %0d pulses want 0", got_q.size()); end
    n_cmp++; if (start_cyc_q.size() != 1) begin n_bad++; $display("FAIL rst_idle_start: got %0d starts want 1", start_cyc_q.size()); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    key_a  = 128'h000102030405060708090a0b0c0d0e0f;
    sync_a = 128'hdeadbeefcafef00d0123456789abcdef;
    key_v  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    sync_v = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    test_reset();
    test_missing_key();
    test_key_load();
    test_counter_seq();
    test_back_to_back();
    test_wrap();
    test_abort_key();
    test_abort_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keystream_gen.md
# keystream_gen

Counter-mode keystream generator for the AES-128 datapath: the responder for `data_flow_control`. It answers `key_and_sync_req` with `key_and_sync_vld` and `new_sync_req` with `cipher_block` / `cipher_block_vld`. It drives the AES round core through a start/done handshake to encrypt the counter block {sync nonce, block counter}. Key and sync values arrive from the host config path and take effect only at message start.

## Interface
- `CTR_W`, 32: width of the block-counter field in the low bits of the counter block (1..64).
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `key_in`  in  128  host key.
- `sync_in`  in  128  host sync/nonce; only bits [127:CTR_W] are used.
- `key_sync_load`  in  1  1-cycle strobe that captures `key_in`/`sync_in` into the staging registers.
- `key_and_sync_req`  in  1  1-cycle pulse from `data_flow_control` at message start.
- `new_sync_req`  in  1  1-cycle pulse requesting the next keystream block.
- `key_and_sync_vld`  out  1  1-cycle pulse: active key and sync are loaded and the counter is cleared.
- `cipher_block`  out  128  keystream block (`aes_model_pack::byte_table`).
- `cipher_block_vld`  out  1  1-cycle pulse qualifying `cipher_block`.
- `aes_key`  out  128  active key to the AES core.
- `aes_block`  out  128  counter block, equal to {active_sync[127:CTR_W], ctr}.
- `aes_start`  out  1  1-cycle start pulse to the AES core.
- `aes_done`  in  1  1-cycle completion pulse from the AES core.
- `aes_result`  in  128  encrypted block, valid while `aes_done` is high.
- `ctr_overflow`  out  1  sticky flag: the counter wrapped within the current message.

## Operation
- Registers:
  - Staging key/sync plus `stg_vld` flag, loaded on `key_sync_load`.
  - Active key/sync, copied from staging when `key_and_sync_req` is accepted.
  - `ctr[CTR_W-1:0]`.
  - `pend` (one pending block request).
- States:
  - IDLE: waiting for `key_and_sync_req`.
  - WAIT_KEY: request seen, but `stg_vld` is 0.
  - READY: key loaded, no AES operation in flight.
  - BUSY: `aes_start` issued, waiting for `aes_done`.
- IDLE/READY/BUSY + `key_and_sync_req`:
  - If `stg_vld`: copy staging to active, clear `ctr`, `pend` and `ctr_overflow`, pulse `key_and_sync_vld`, go to READY.
  - Otherwise go to WAIT_KEY.
  - Any in-flight AES result is discarded: the `aes_done` that follows is ignored.
- WAIT_KEY + `key_sync_load`: in the next cycle, perform the accept action above.
- READY + (`new_sync_req` or `pend`):
  - Pulse `aes_start` with `aes_block` = {sync, ctr}.
  - Increment `ctr` modulo 2^CTR_W.
  - Clear `pend`.
  - Go to BUSY.
- BUSY + `new_sync_req`: set `pend`. A further request while `pend` is already set is dropped.
- BUSY + `aes_done`: register `aes_result` into `cipher_block`, pulse `cipher_block_vld`, go to READY.
- `new_sync_req` in IDLE or WAIT_KEY: ignored.
- Same-cycle `key_and_sync_req` and `new_sync_req`: the key request wins and `new_sync_req` is dropped.
- Counter wrap (`ctr` increments from all-ones to 0): set `ctr_overflow`. It stays set until the next accepted `key_and_sync_req`.
- `key_sync_load` at any time updates staging only. `aes_key` and `aes_block` never change while in BUSY.

## Timing
- Reset values:
  - `key_and_sync_vld`, `cipher_block_vld`, `aes_start`, `ctr_overflow`: 0.
  - `cipher_block`, `aes_key`, `aes_block`: 0.
  - `ctr` and `pend`: 0; `stg_vld`: 0; state IDLE.
- Reset mid-operation: return to IDLE immediately. A pending `aes_done` after reset is ignored.
- `key_and_sync_req` at cycle N with `stg_vld`=1 → `key_and_sync_vld` at N+1.
- `new_sync_req` at N in READY → `aes_start` at N+1.
- `aes_done` at M → `cipher_block_vld` at M+1.
- `cipher_block` holds its value until the next `cipher_block_vld`.
- `pend` set at BUSY exit → `aes_start` in the cycle after `cipher_block_vld`.

## Configuration
- `KEYSTREAM_PREFETCH_EN` defined:
  - On entering READY with the one-entry prefetch buffer empty, start the AES operation for the next block automatically.
  - The result fills the buffer; no `cipher_block_vld` is generated on fill.
  - `new_sync_req` with the buffer full → `cipher_block_vld` at N+1 from the buffer, and the next prefetch starts in the same cycle.
  - With the buffer empty, `new_sync_req` sets `pend` and the completing `aes_done` delivers directly.
  - An accepted `key_and_sync_req` invalidates the buffer.
- `KEYSTREAM_PREFETCH_EN` undefined: on-demand generation only, as in Operation.

## Test plan
- Key/sync load:
  - Stimulus: `key_sync_load` with key=128'h2b7e…3c, sync=128'hF0F1…FF; then `key_and_sync_req`.
  - Required: `key_and_sync_vld` 1 cycle later; `aes_key`=key.
- Counter sequence:
  - Stimulus: three `new_sync_req`, with a stub core (done after 10 cycles, result=block^128'h1).
  - Required: `aes_block` low word 0, 1, 2; three `cipher_block_vld` pulses with the matching data.
- Request during BUSY:
  - Stimulus: second `new_sync_req` in BUSY, then a third.
  - Required: exactly one extra block, `aes_start` the cycle after the first `cipher_block_vld`; the third request is dropped.
- Missing key:
  - Stimulus: `key_and_sync_req` with no prior load.
  - Required: no `key_and_sync_vld`; after `key_sync_load` at cycle K, `key_and_sync_vld` at K+2.
- Wrap with CTR_W=4:
  - Stimulus: 17 requests.
  - Required: the 17th `aes_block` low nibble is 0; `ctr_overflow`=1; the next `key_and_sync_req` clears it.
- Abort mid-flight:
  - Stimulus: `key_and_sync_req` in BUSY, or `rst` low in BUSY.
  - Required: the following `aes_done` produces no `cipher_block_vld`; outputs go to their reset/cleared values.
